morse_sequenciador: RTL

Controller that sequences the Morse codifier for one character at a time and plays the result out as timed on/off keying on a single tone output. It accepts a character code (0-9 digits, 10-35 letters A-Z) through a valid/accept handshake and drives the codifier's num/ready inputs. It then captures the codifier's morse/display vectors and emits dots, dashes and gaps with standard 1:3 timing. It sits between the character source (keypad/UART front end) and the codifier plus the buzzer/LED driver.

---
 rtl/morse_sequenciador.sv | 116 +++++++++++
 1 files changed

// File: rtl/morse_sequenciador.sv
// morse_sequenciador: drives the Morse codifier one character at a time and keys the result as timed on/off tone
module morse_sequenciador #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] num_in,
  input  logic       valid,
  output logic       accept,
  output logic [5:0] cod_num,
  output logic       cod_ready,
  input  logic [4:0] cod_morse,
  input  logic [4:0] cod_display,
  output logic       tone,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] MARK    = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;
  localparam logic [2:0] CHARGAP = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [CNT_W-1:0] DOT_N  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_N = CNT_W'(3 * UNIT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       morse_q, morse_d;
  logic [4:0]       disp_q, disp_d;
  logic [5:0]       num_q, num_d;
  logic             tone_q, tone_d;
  logic [4:0]       lower;
  logic [2:0]       load_idx, next_idx;

  function automatic logic [2:0] top_bit(input logic [4:0] v);
    top_bit = 3'd0;
    for (int i = 0; i < 5; i++) if (v[i]) top_bit = 3'(i);
  endfunction

  assign lower     = disp_q & ((5'd1 << idx_q) - 5'd1);
  assign load_idx  = top_bit(cod_display);
  assign next_idx  = top_bit(lower);
  assign accept    = valid & (state_q == IDLE);
  assign cod_ready = (state_q == REQ) & (num_q <= 6'd35);
  assign err       = (state_q == REQ) & (num_q > 6'd35);
  assign done      = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign cod_num   = num_q;
  assign tone      = tone_q;

  // next-state, element timing and element index walk from most to least significant used position
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    morse_d = morse_q;
    disp_d  = disp_q;
    num_d   = num_q;
    case (state_q)
      IDLE: begin
        state_d = valid ? REQ : IDLE;
        num_d   = valid ? num_in : num_q;
      end
      REQ: state_d = (num_q > 6'd35) ? IDLE : LOAD;
      LOAD: begin
        morse_d = cod_morse;
        disp_d  = cod_display;
        idx_d   = load_idx;
        state_d = (cod_display == 5'd0) ? CHARGAP : MARK;
        cnt_d   = (cod_display == 5'd0 || cod_morse[load_idx]) ? DASH_N : DOT_N;
      end
      MARK: begin
        state_d = (cnt_q != '0) ? MARK : (lower != 5'd0) ? GAP : CHARGAP;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : (lower != 5'd0) ? DOT_N : DASH_N;
      end
      GAP: begin
        state_d = (cnt_q != '0) ? GAP : MARK;
        idx_d   = (cnt_q != '0) ? idx_q : next_idx;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : morse_q[next_idx] ? DASH_N : DOT_N;
      end
      CHARGAP: begin
        state_d = (cnt_q != '0) ? CHARGAP : DONE;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tone_d = state_d == MARK;
  end

  // state registers; reset aborts any character in progress and silences the tone at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      morse_q <= 5'd0;
      disp_q  <= 5'd0;
      num_q   <= 6'd0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      morse_q <= morse_d;
      disp_q  <= disp_d;
      num_q   <= num_d;
      tone_q  <= tone_d;
    end
  end
endmodule
